// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access sizes, FSM states,
// write-back control bit positions and the latched load-lane context.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Lane/extension information captured at issue so the load path does not
    // depend on the upstream register staying frozen.
    typedef struct packed {
        logic [1:0]        off;
        logic [SIZE_W-1:0] size;
        logic              uns;
    } ld_ctx_t;

    function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                           input logic [1:0]        off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus req/ack interface between the MEM stage (master) and data memory.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              dbus_req;
    logic              dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [BE_W-1:0]   dbus_be;
    logic [DATA_W-1:0] dbus_wdata;
    logic              dbus_ack;
    logic [DATA_W-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated data,
// misalignment detection, and load lane select with sign/zero extension.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [SIZE_W-1:0] size,
    input  logic [DATA_W-1:0] store_data,
    input  ld_ctx_t           ld_ctx,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata,
    output logic              misalign,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign misalign = is_misaligned(size, addr_lo);

    // Store side
    always_comb begin
        be    = '0;
        wdata = '0;
        case (size)
            SZ_BYTE: begin
                be    = BE_W'(4'b0001 << addr_lo);
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = '0;
                wdata = '0;
            end
        endcase
    end

    // Load side
    always_comb begin
        ld_byte = 8'h00;
        ld_half = ld_ctx.off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_ctx.off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
    end

    always_comb begin
        ld_data = '0;
        case (ld_ctx.size)
            SZ_BYTE: ld_data = ld_ctx.uns ? {24'h000000, ld_byte}
                                          : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ld_ctx.uns ? {16'h0000, ld_half}
                                          : {{16{ld_half[15]}}, ld_half};
            SZ_WORD: ld_data = rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns the EX result into a req/ack data-bus access,
// stalls until completion or timeout, and hands load data to MEM/WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [SIZE_W-1:0]  mem_size,
    input  logic               mem_unsigned,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [DATA_W-1:0]  store_data_in,
    input  logic [WB_W-1:0]    wb_in,
    input  logic [4:0]         rfile_wn_in,
    mem_access_stage_if.master dbus,
    output logic               stall,
    output logic [WB_W-1:0]    wb_out,
    output logic [DATA_W-1:0]  dmem_rdata_out,
    output logic [DATA_W-1:0]  ALU_result_out,
    output logic [4:0]         rfile_wn_out,
    output logic               err_misalign,
    output logic               err_timeout
);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_flag;
    logic [DATA_W-1:0] hold;
    ld_ctx_t           ld_ctx;

    logic              access;
    logic              misalign;
    logic              start;
    logic              timeout_hit;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_data;

    assign access      = valid_in & (mem_read | mem_write);
    assign start       = (state == ST_IDLE) & access & ~misalign;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign ALU_result_out = alu_result_in;
    assign rfile_wn_out   = rfile_wn_in;

    mem_lane_align u_lane_align (
        .addr_lo    (alu_result_in[1:0]),
        .size       (mem_size),
        .store_data (store_data_in),
        .ld_ctx     (ld_ctx),
        .rdata      (dbus.dbus_rdata),
        .be         (st_be),
        .wdata      (st_wdata),
        .misalign   (misalign),
        .ld_data    (ld_data)
    );

    // Bus request FSM; all bus-facing fields and err_timeout are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            err_flag        <= 1'b0;
            hold            <= '0;
            ld_ctx          <= '0;
            err_timeout     <= 1'b0;
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_be    <= '0;
            dbus.dbus_wdata <= '0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dbus.dbus_req   <= 1'b1;
                        dbus.dbus_we    <= mem_write;
                        dbus.dbus_addr  <= {alu_result_in[ADDR_W-1:2], 2'b00};
                        dbus.dbus_be    <= st_be;
                        dbus.dbus_wdata <= st_wdata;
                        ld_ctx          <= '{off: alu_result_in[1:0],
                                             size: mem_size,
                                             uns: mem_unsigned};
                        wait_cnt        <= '0;
                        hold            <= '0;
                        err_flag        <= 1'b0;
                        state           <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dbus.dbus_ack) begin
                        dbus.dbus_req <= 1'b0;
                        hold          <= dbus.dbus_we ? '0 : ld_data;
                        state         <= ST_DONE;
                    end else if (timeout_hit) begin
                        dbus.dbus_req <= 1'b0;
                        err_timeout   <= 1'b1;
                        err_flag      <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    err_flag <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pipeline-facing outputs; forced quiet while reset is asserted.
    always_comb begin
        stall          = 1'b0;
        err_misalign   = 1'b0;
        wb_out         = '0;
        dmem_rdata_out = '0;
        if (!rst) begin
            wb_out[WB_REGWRITE] = wb_in[WB_REGWRITE];
            wb_out[WB_MEMTOREG] = wb_in[WB_MEMTOREG];
            case (state)
                ST_IDLE: begin
                    stall = start;
                    if (access && misalign) begin
                        err_misalign        = 1'b1;
                        wb_out[WB_REGWRITE] = 1'b0;
                    end
                end
                ST_BUSY: stall = 1'b1;
                ST_DONE: begin
                    dmem_rdata_out = hold;
                    if (err_flag) begin
                        wb_out[WB_REGWRITE] = 1'b0;
                    end
                end
                default: stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size, wb_in, wb_out;
    logic [31:0] alu_result_in, store_data_in, dmem_rdata_out, ALU_result_out;
    logic [4:0]  rfile_wn_in, rfile_wn_out;
    logic        stall, err_misalign, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_nreq, r_nstall;
    logic        r_done, r_we, r_errm, r_errt;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_dmem, r_alu;
    logic [1:0]  r_wb;
    logic [4:0]  r_wn;

    always #5 clk = ~clk;

    mem_access_stage_if dbus();

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .wb_in          (wb_in),
        .rfile_wn_in    (rfile_wn_in),
        .dbus           (dbus),
        .stall          (stall),
        .wb_out         (wb_out),
        .dmem_rdata_out (dmem_rdata_out),
        .ALU_result_out (ALU_result_out),
        .rfile_wn_out   (rfile_wn_out),
        .err_misalign   (err_misalign),
        .err_timeout    (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    // Drives one EX/MEM instruction, acks on BUSY cycle ack_at (0 = never),
    // and records what the stage presented through to the handoff cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [1:0] wb, input int ack_at, input logic [31:0] rdata);
        int busy_i;
        valid_in = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_unsigned = uns; alu_result_in = addr; store_data_in = sd;
        wb_in = wb; rfile_wn_in = 5'd9; dbus.dbus_rdata = rdata;
        r_nreq = 0; r_nstall = 0; r_done = 1'b0; busy_i = 0;
        r_we = 1'b0; r_be = '0; r_addr = '0; r_wdata = '0;
        r_dmem = '0; r_wb = '0; r_errm = 1'b0; r_errt = 1'b0; r_alu = '0; r_wn = '0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (!stall) begin
                r_done = 1'b1;
                r_dmem = dmem_rdata_out;
                r_wb   = wb_out;
                r_errm = err_misalign;
                r_errt = err_timeout;
                r_alu  = ALU_result_out;
                r_wn   = rfile_wn_out;
                break;
            end
            r_nstall++;
            if (dbus.dbus_req) begin
                r_nreq++;
                busy_i++;
                if (busy_i == 1) begin
                    r_we = dbus.dbus_we; r_be = dbus.dbus_be;
                    r_addr = dbus.dbus_addr; r_wdata = dbus.dbus_wdata;
                end
                dbus.dbus_ack = (busy_i == ack_at);
            end
            @(posedge clk);
            #1;
            dbus.dbus_ack = 1'b0;
        end
        check("txn_completes", 32'(r_done), 32'd1);
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = SZ_WORD;
        mem_unsigned = 1'b0; alu_result_in = 32'h401; store_data_in = '0;
        wb_in = 2'b11; rfile_wn_in = '0;
        dbus.dbus_ack = 1'b0; dbus.dbus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dbus.dbus_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wb_out", 32'(wb_out), 32'd0);
        check("rst_err_misalign", 32'(err_misalign), 32'd0);
        check("rst_addr", dbus.dbus_addr, 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        clear_inputs();
        rst = 1'b0;
        tick();

        // Word load, ack on third BUSY cycle
        run_txn(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 2'b11, 3, 32'hDEADBEEF);
        check("wl_nreq", 32'(r_nreq), 32'd3);
        check("wl_nstall", 32'(r_nstall), 32'd4);
        check("wl_rdata", r_dmem, 32'hDEADBEEF);
        check("wl_wb", 32'(r_wb), 32'd3);
        check("wl_addr", r_addr, 32'h100);
        check("wl_be", 32'(r_be), 32'hF);
        check("wl_we", 32'(r_we), 32'd0);
        check("wl_alu_pass", r_alu, 32'h100);
        check("wl_wn_pass", 32'(r_wn), 32'd9);
        check("wl_idle_rdata", dmem_rdata_out, 32'd0);

        // Byte store at 0x203 with mem_read also set: store wins
        run_txn(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h203, 32'h123456AB, 2'b00, 1, 32'h0);
        check("bs_addr", r_addr, 32'h200);
        check("bs_be", 32'(r_be), 32'h8);
        check("bs_wdata", r_wdata, 32'hABABABAB);
        check("bs_we", 32'(r_we), 32'd1);
        check("bs_nreq", 32'(r_nreq), 32'd1);
        check("bs_nstall_min", 32'(r_nstall), 32'd2);
        check("bs_rdata", r_dmem, 32'd0);
        check("bs_errt", 32'(r_errt), 32'd0);

        // Half store at 0x002
        run_txn(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h002, 32'h12345678, 2'b00, 2, 32'h0);
        check("hs_be", 32'(r_be), 32'hC);
        check("hs_wdata", r_wdata, 32'h56785678);

        // Half loads at 0x302, signed then unsigned
        run_txn(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h302, 32'h0, 2'b11, 1, 32'h80011234);
        check("hl_signed", r_dmem, 32'hFFFF8001);
        check("hl_be", 32'(r_be), 32'hC);
        run_txn(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h302, 32'h0, 2'b11, 1, 32'h80011234);
        check("hl_unsigned", r_dmem, 32'h00008001);

        // Signed byte load at 0x101
        run_txn(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, 2'b11, 2, 32'h11228344);
        check("bl_signed", r_dmem, 32'hFFFFFF83);
        check("bl_be", 32'(r_be), 32'h2);

        // Misaligned word load at 0x401
        run_txn(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h401, 32'h0, 2'b11, 1, 32'h0);
        check("mis_nstall", 32'(r_nstall), 32'd0);
        check("mis_errm", 32'(r_errm), 32'd1);
        check("mis_wb", 32'(r_wb), 32'd1);
        check("mis_noreq", 32'(dbus.dbus_req), 32'd0);

        // Illegal size
        run_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 2'b11, 1, 32'h0);
        check("ill_errm", 32'(r_errm), 32'd1);
        check("ill_nreq", 32'(r_nreq), 32'd0);

        // Timeout: no ack
        run_txn(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h600, 32'h0, 2'b11, 0, 32'h55AA55AA);
        check("to_nreq", 32'(r_nreq), 32'd16);
        check("to_nstall", 32'(r_nstall), 32'd17);
        check("to_errt", 32'(r_errt), 32'd1);
        check("to_wb", 32'(r_wb), 32'd1);
        check("to_rdata", r_dmem, 32'd0);
        check("to_pulse_once", 32'(err_timeout), 32'd0);

        // Ack on the cycle the timeout would expire: ack wins
        run_txn(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h700, 32'h0, 2'b11, 16, 32'hCAFEF00D);
        check("tack_errt", 32'(r_errt), 32'd0);
        check("tack_wb", 32'(r_wb), 32'd3);
        check("tack_rdata", r_dmem, 32'hCAFEF00D);

        // valid_in=0 with mem_read set: no access
        valid_in = 1'b0; mem_read = 1'b1; mem_size = SZ_WORD; alu_result_in = 32'h800;
        #1;
        check("nv_stall", 32'(stall), 32'd0);
        tick();
        check("nv_req", 32'(dbus.dbus_req), 32'd0);
        clear_inputs();

        // Stray ack while IDLE
        dbus.dbus_ack = 1'b1; dbus.dbus_rdata = 32'h13579BDF;
        tick();
        dbus.dbus_ack = 1'b0;
        check("stray_req", 32'(dbus.dbus_req), 32'd0);
        check("stray_rdata", dmem_rdata_out, 32'd0);
        check("stray_stall", 32'(stall), 32'd0);

        // Asynchronous reset in the middle of BUSY
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = SZ_WORD;
        alu_result_in = 32'h900; wb_in = 2'b11;
        tick();
        check("mid_busy_req", 32'(dbus.dbus_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(dbus.dbus_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_wb", 32'(wb_out), 32'd0);
        clear_inputs();
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_req", 32'(dbus.dbus_req), 32'd0);
        run_txn(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hA00, 32'h0, 2'b11, 2, 32'h0F0F0F0F);
        check("post_rst_nreq", 32'(r_nreq), 32'd2);
        check("post_rst_rdata", r_dmem, 32'h0F0F0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts the EX result into a data-bus transaction with a req/ack handshake.
- Handles byte, halfword and word lane steering, and sign/zero extension of loads.
- Stalls the pipeline until the bus acknowledges, then presents write-back data and control to MEM/WB.

Parameters:
TIMEOUT, 16, bus cycles without dbus_ack before abort; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must hold TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_in  in  1  EX/MEM slot holds a real instruction
mem_read  in  1  load request
mem_write  in  1  store request; wins if mem_read is also set
mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
alu_result_in  in  32  effective address / ALU result
store_data_in  in  32  store operand (low bits significant)
wb_in  in  2  {RegWrite, MemToReg}
rfile_wn_in  in  5  destination register
dbus_req  out  1  bus request (registered)
dbus_we  out  1  write enable (registered)
dbus_addr  out  32  word-aligned address, {addr[31:2],2'b00} (registered)
dbus_be  out  4  byte enables (registered)
dbus_wdata  out  32  lane-replicated store data (registered)
dbus_ack  in  1  bus completion, one-cycle pulse
dbus_rdata  in  32  read word, valid when dbus_ack=1
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert no bubble into MEM/WB
wb_out  out  2  {RegWrite, MemToReg} to MEM/WB; RegWrite forced to 0 on any error
dmem_rdata_out  out  32  extended load data
ALU_result_out  out  32  alu_result_in passthrough
rfile_wn_out  out  5  rfile_wn_in passthrough
err_misalign  out  1  one-cycle pulse: misaligned or illegal size
err_timeout  out  1  one-cycle pulse: bus timeout abort

Behaviour:

Access validity:
- access = valid_in & (mem_read | mem_write).
- Misaligned when size=11, half with addr[0]=1, or word with addr[1:0]≠0.

FSM states: IDLE, BUSY, DONE.
- IDLE, access, aligned:
  - Next edge: dbus_req=1, dbus_we=mem_write; addr, be and wdata latched; wait counter cleared; go BUSY.
  - stall=1 combinationally in that cycle.
- IDLE, access, misaligned:
  - No bus request; err_misalign=1 combinationally for that cycle; stall=0.
  - wb_out[1]=0; instruction retires as a no-op.
- IDLE, no access: stall=0; outputs pass through; dmem_rdata_out=0.
- BUSY:
  - stall=1; request fields held stable.
  - On dbus_ack: dbus_req drops next edge; for a load, extended rdata is captured into the hold register; go DONE.
  - No ack for TIMEOUT cycles: dbus_req drops; err_timeout pulses for one cycle (registered); error flag set; go DONE.
- DONE:
  - stall=0 for exactly one cycle; dmem_rdata_out=hold register; MEM/WB captures at the edge.
  - wb_out[1]=0 if the error flag is set; error flag cleared; go IDLE.
  - A new access seen in DONE is not started until IDLE. The upstream stage advances on the same edge, so the next access is evaluated in IDLE one cycle later.
- Total latency for an ack after N cycles in BUSY: N+2 cycles of stall-free handoff; minimum stall is 2 cycles (issue plus one BUSY cycle with an immediate ack).

Lane rules (a = addr[1:0]):
- Byte: be = 1<<a; wdata = {4{sd[7:0]}}; load selects byte lane a.
- Half: be = a[1] ? 1100 : 0011; wdata = {2{sd[15:0]}}; load selects half a[1].
- Word: be = 1111; wdata = sd; load uses the full word.
- Extension uses mem_unsigned; stores do not touch dmem_rdata_out (hold register cleared to 0).

Boundary conditions:
- dbus_ack outside BUSY is ignored.
- dbus_ack on the same cycle the timeout expires: ack wins, no error.
- valid_in=0 with read/write set: no access.

Reset (asynchronous, mid-transaction included):
- State IDLE; dbus_req, dbus_we, dbus_be, dbus_addr and dbus_wdata are 0; hold register is 0.
- Counter and error flag are 0; err_timeout is 0.
- Combinational outputs while rst=1: stall=0, wb_out=00, err_misalign=0.
- A bus transaction aborted by reset is abandoned; the bus is required to tolerate req dropping.

Decomposition:
- Shared package: mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings, WB bit indices (WB_REGWRITE=1, WB_MEMTOREG=0).
- One natural sub-module: mem_lane_align (combinational). Store be/wdata generation, load lane select/extend and misalign detection.

Test Plan:
- Word load at 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> dbus_req high 3 cycles; stall high 4 cycles then low 1; dmem_rdata_out=0xDEADBEEF; wb_out=11.
- Byte store 0xAB at 0x203 -> dbus_addr=0x200, be=1000, wdata=0xABABABAB, dbus_we=1; one transaction, no error.
- Signed half load at 0x302, rdata 0x8001_1234 -> dmem_rdata_out=0xFFFF8001; same with mem_unsigned=1 -> 0x00008001.
- Word load at 0x401 -> no dbus_req; err_misalign pulse; wb_out[1]=0; stall=0.
- No ack, TIMEOUT=16 -> req drops after 16 BUSY cycles; err_timeout pulses once; wb_out[1]=0 in DONE.
- rst asserted in BUSY, mid-cycle -> dbus_req, stall and wb_out go to 0 immediately, before the next edge; state IDLE after release.
